// File: rtl/mioc_pkg.sv
// Shared constants for the mioc flop bank: set/reset priority encoding,
// default sizing, and the per-channel next-state resolution helper.
package mioc_pkg;

    // Encoding of the RST_PRIO parameter
    localparam int PRIO_RESET = 1;
    localparam int PRIO_SET   = 0;

    // Default sizing
    localparam int NCH_DEF = 8;
    localparam int CW_DEF  = 8;

    // Next q for one channel given its set/reset events and priority bit.
    // On a simultaneous set and reset the result is the inverse of prio_bit.
    function automatic logic resolve_q(
        input logic q_cur,
        input logic set_ev,
        input logic rst_ev,
        input logic prio_bit
    );
        if (set_ev && rst_ev) begin
            return ~prio_bit;
        end else if (set_ev) begin
            return 1'b1;
        end else if (rst_ev) begin
            return 1'b0;
        end
        return q_cur;
    endfunction

endpackage

// File: rtl/mioc_flop_chan.sv
// One set/reset flop channel: optional input synchronizer, edge detection,
// set/reset priority resolution, q register and registered change flag.
// Build option: define MIOC_FLOP_BANK_SYNC_EN to insert a 2-flop
// synchronizer on every event input (event-to-q latency becomes 3 clocks).
module mioc_flop_chan
    import mioc_pkg::*;
#(
    parameter int RST_PRIO  = PRIO_RESET,
    parameter bit QINIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic rpe_raw,
    input  logic rne_raw,
    output logic q,
    output logic q_next,
    output logic chg
);

    localparam logic PRIO_BIT = RST_PRIO[0];

    logic set_s;
    logic rpe_s;
    logic rne_s;

`ifdef MIOC_FLOP_BANK_SYNC_EN
    logic [1:0] set_sync;
    logic [1:0] rpe_sync;
    logic [1:0] rne_sync;

    // Two-stage synchronizers; preloaded with the raw level so reset exit is quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            set_sync <= {set_raw, set_raw};
            rpe_sync <= {rpe_raw, rpe_raw};
            rne_sync <= {rne_raw, rne_raw};
        end else begin
            set_sync <= {set_sync[0], set_raw};
            rpe_sync <= {rpe_sync[0], rpe_raw};
            rne_sync <= {rne_sync[0], rne_raw};
        end
    end

    assign set_s = set_sync[1];
    assign rpe_s = rpe_sync[1];
    assign rne_s = rne_sync[1];
`else
    assign set_s = set_raw;
    assign rpe_s = rpe_raw;
    assign rne_s = rne_raw;
`endif

    logic set_prev;
    logic rpe_prev;
    logic rne_prev;
    logic set_ev;
    logic rst_ev;

    // Previous-value registers; reset captures the current level so no event fires after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            set_prev <= set_raw;
            rpe_prev <= rpe_raw;
            rne_prev <= rne_raw;
        end else begin
            set_prev <= set_s;
            rpe_prev <= rpe_s;
            rne_prev <= rne_s;
        end
    end

    // Edge detection and next-state resolution
    always_comb begin
        set_ev = set_s & ~set_prev;
        rst_ev = (rpe_s & ~rpe_prev) | (~rne_s & rne_prev);
        q_next = resolve_q(q, set_ev, rst_ev, PRIO_BIT);
    end

    // Flop state and one-cycle change flag; reset-induced changes raise no flag
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= QINIT_BIT;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;
        end
    end

endmodule

// File: rtl/mioc_flop_bank.sv
// Bank of NCH independent edge-triggered set/reset flops with a shared
// saturating transition counter.
// Build option: define MIOC_FLOP_BANK_SYNC_EN to synchronize every event
// input through two flops (event-to-q latency 3 clocks instead of 1).
module mioc_flop_bank
    import mioc_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int RST_PRIO = PRIO_RESET,
    parameter bit QINIT    = 1'b0,
    parameter int CW       = CW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] set_i,
    input  logic [NCH-1:0] rpe_i,
    input  logic [NCH-1:0] rne_i,
    input  logic           cnt_clr_i,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] qbar,
    output logic [NCH-1:0] chg_o,
    output logic [CW-1:0]  evt_cnt_o
);

    // Popcount width covers up to 32 channels changing at once
    localparam int PW = 6;
    localparam int SW = CW + PW;

    logic [NCH-1:0] q_next;
    logic [PW-1:0]  pop;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mioc_flop_chan #(
            .RST_PRIO  (RST_PRIO),
            .QINIT_BIT (QINIT)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .set_raw (set_i[i]),
            .rpe_raw (rpe_i[i]),
            .rne_raw (rne_i[i]),
            .q       (q[i]),
            .q_next  (q_next[i]),
            .chg     (chg_o[i])
        );
    end

    assign qbar = ~q;

    // Saturating add of this cycle's transition count onto the counter
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({CW{1'b1}})) begin
            return {CW{1'b1}};
        end
        return s[CW-1:0];
    endfunction

    // Number of channels whose q changes on the coming edge
    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + PW'(q_next[i] ^ q[i]);
        end
    end

    // Event counter; clear takes precedence over that cycle's increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_i) begin
            evt_cnt_o <= '0;
        end else begin
            evt_cnt_o <= sat_add(evt_cnt_o, pop);
        end
    end

endmodule

// File: tb/tb_mioc_flop_bank.sv
// Directed bench for mioc_flop_bank: three instances share stimulus
// (default, set-priority, 4-bit counter); expected values are hand-derived.
module tb_mioc_flop_bank;

`ifdef MIOC_FLOP_BANK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] set_i;
    logic [7:0] rpe_i;
    logic [7:0] rne_i;
    logic       cnt_clr_i;

    logic [7:0] q_a, qbar_a, chg_a, cnt_a;
    logic [7:0] q_s, qbar_s, chg_s, cnt_s;
    logic [7:0] q_c, qbar_c, chg_c;
    logic [3:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mioc_flop_bank #(.NCH(8), .RST_PRIO(1), .QINIT(1'b0), .CW(8)) dut (
        .clk(clk), .rst(rst), .set_i(set_i), .rpe_i(rpe_i), .rne_i(rne_i),
        .cnt_clr_i(cnt_clr_i), .q(q_a), .qbar(qbar_a), .chg_o(chg_a), .evt_cnt_o(cnt_a)
    );

    mioc_flop_bank #(.NCH(8), .RST_PRIO(0), .QINIT(1'b0), .CW(8)) dut_sp (
        .clk(clk), .rst(rst), .set_i(set_i), .rpe_i(rpe_i), .rne_i(rne_i),
        .cnt_clr_i(cnt_clr_i), .q(q_s), .qbar(qbar_s), .chg_o(chg_s), .evt_cnt_o(cnt_s)
    );

    mioc_flop_bank #(.NCH(8), .RST_PRIO(1), .QINIT(1'b0), .CW(4)) dut_c4 (
        .clk(clk), .rst(rst), .set_i(set_i), .rpe_i(rpe_i), .rne_i(rne_i),
        .cnt_clr_i(cnt_clr_i), .q(q_c), .qbar(qbar_c), .chg_o(chg_c), .evt_cnt_o(cnt_c)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; set_i = '0; rpe_i = '0; rne_i = '0; cnt_clr_i = 1'b0;
        tick(2);
        check("rst_q",    32'(q_a),    32'h00);
        check("rst_qbar", 32'(qbar_a), 32'hFF);
        check("rst_chg",  32'(chg_a),  32'h00);
        check("rst_cnt",  32'(cnt_a),  32'h00);
        rst = 1'b0;
        tick(1);
        check("post_rst_q", 32'(q_a), 32'h00);

        // Set channel 0
        set_i = 8'h01;
        tick(LAT);
        check("set0_q",    32'(q_a),    32'h01);
        check("set0_qbar", 32'(qbar_a), 32'hFE);
        check("set0_chg",  32'(chg_a),  32'h01);
        check("set0_cnt",  32'(cnt_a),  32'h01);
        tick(1);
        check("set0_chg_gone", 32'(chg_a), 32'h00);
        check("set0_hold_q",   32'(q_a),   32'h01);
        check("set0_hold_cnt", 32'(cnt_a), 32'h01);

        // Channel 3: set, then falling-edge reset, then rising rne has no effect
        set_i = 8'h09;
        tick(LAT);
        check("set3_q", 32'(q_a), 32'h09);
        rne_i = 8'h08;
        tick(LAT);
        check("rne_rise_q", 32'(q_a), 32'h09);
        rne_i = 8'h00;
        tick(LAT);
        check("rne_fall_q",   32'(q_a),   32'h01);
        check("rne_fall_chg", 32'(chg_a), 32'h08);
        check("rne_fall_cnt", 32'(cnt_a), 32'h03);
        rne_i = 8'h08;
        tick(LAT);
        check("rne_rise2_q",   32'(q_a),   32'h01);
        check("rne_rise2_chg", 32'(chg_a), 32'h00);
        check("rne_rise2_cnt", 32'(cnt_a), 32'h03);

        // Simultaneous set and rpe on channel 5
        set_i = 8'h29;
        rpe_i = 8'h20;
        tick(LAT);
        check("both_rprio_q",   32'(q_a),   32'h01);
        check("both_rprio_chg", 32'(chg_a), 32'h00);
        check("both_rprio_cnt", 32'(cnt_a), 32'h03);
        check("both_sprio_q",   32'(q_s),   32'h21);
        check("both_sprio_chg", 32'(chg_s), 32'h20);
        check("both_sprio_cnt", 32'(cnt_s), 32'h04);

        set_i = 8'h00; rpe_i = 8'h00; rne_i = 8'h00;
        tick(LAT + 1);
        check("quiet_q_a", 32'(q_a), 32'h01);
        check("quiet_q_s", 32'(q_s), 32'h21);

        // 20 toggles on channel 7
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                set_i = 8'h80; rpe_i = 8'h00;
            end else begin
                set_i = 8'h00; rpe_i = 8'h80;
            end
            tick(1);
        end
        set_i = 8'h00; rpe_i = 8'h00;
        tick(LAT + 1);
        check("tog_q_a",   32'(q_a),   32'h01);
        check("tog_cnt_a", 32'(cnt_a), 32'd23);
        check("tog_cnt_s", 32'(cnt_s), 32'd24);
        check("tog_cnt_c", 32'(cnt_c), 32'd15);

        // Clear coincident with a channel 7 set event
        set_i = 8'h80;
        tick(LAT - 1);
        cnt_clr_i = 1'b1;
        tick(1);
        cnt_clr_i = 1'b0;
        check("clr_q_a",   32'(q_a),   32'h81);
        check("clr_chg_a", 32'(chg_a), 32'h80);
        check("clr_cnt_a", 32'(cnt_a), 32'h00);
        check("clr_cnt_s", 32'(cnt_s), 32'h00);
        check("clr_cnt_c", 32'(cnt_c), 32'h0);
        tick(1);
        check("clr_after_cnt", 32'(cnt_a), 32'h00);
        check("clr_after_chg", 32'(chg_a), 32'h00);

        // Reset asserted on the cycle a reset event lands; set_i high through reset
        rpe_i = 8'h80;
        tick(LAT - 1);
        rst = 1'b1;
        set_i = 8'hFF;
        tick(1);
        check("midrst_q",   32'(q_a),   32'h00);
        check("midrst_chg", 32'(chg_a), 32'h00);
        check("midrst_cnt", 32'(cnt_a), 32'h00);
        check("midrst_q_s", 32'(q_s),   32'h00);
        tick(2);
        rst = 1'b0;
        tick(LAT + 1);
        check("held_q",    32'(q_a),    32'h00);
        check("held_qbar", 32'(qbar_a), 32'hFF);
        check("held_chg",  32'(chg_a),  32'h00);
        check("held_cnt",  32'(cnt_a),  32'h00);

        // Exact latency of a set on channel 1
        set_i = 8'h00; rpe_i = 8'h00;
        tick(LAT + 1);
        set_i = 8'h02;
        tick(LAT - 1);
        check("lat_early_q", 32'(q_a), 32'h00);
        tick(1);
        check("lat_q",   32'(q_a),   32'h02);
        check("lat_chg", 32'(chg_a), 32'h02);
        check("lat_cnt", 32'(cnt_a), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mioc_flop_bank.md
MIOC_FLOP_BANK -- requirements
Module: mioc_flop_bank

Interface
REQ-001 Parameter NCH, default 8, number of independent set/reset flop channels (1..32).
REQ-002 Parameter RST_PRIO, default 1: 1 means reset wins on simultaneous set/reset events; 0 means set wins.
REQ-003 Parameter QINIT, default 0, value loaded into every q bit on rst.
REQ-004 Parameter CW, default 8, width of the event counter.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port set_i  input  NCH  per-channel set; acts on rising edge.
REQ-008 Port rpe_i  input  NCH  per-channel reset; acts on rising edge.
REQ-009 Port rne_i  input  NCH  per-channel reset; acts on falling edge.
REQ-010 Port cnt_clr_i  input  1  synchronous clear of evt_cnt_o.
REQ-011 Port q  output  NCH  flop state.
REQ-012 Port qbar  output  NCH  complement of q, always ~q.
REQ-013 Port chg_o  output  NCH  one-cycle pulse per channel whose q changed on the previous clock edge.
REQ-014 Port evt_cnt_o  output  CW  saturating count of q transitions, summed over all channels.

Function
REQ-015 Each input bit has a previous-value register; set_ev = set_i & ~set_prev, rpe_ev = rpe_i & ~rpe_prev, rne_ev = ~rne_i & rne_prev.
REQ-016 A channel's reset event is rpe_ev | rne_ev.
REQ-017 Only a set event: q goes to 1. Only a reset event: q goes to 0. Neither: q holds.
REQ-018 Both set and reset events on a channel in the same cycle: q takes ~RST_PRIO[0] (0 when RST_PRIO=1, 1 when RST_PRIO=0).
REQ-019 Latency: the input is sampled at clock edge k, the edge is detected against edge k-1, and q shows the new value after edge k; total latency is one clock.
REQ-020 A level held constant produces no further events; a set event on a channel whose q is already 1 produces no chg_o and no count.
REQ-021 chg_o[i] is registered and asserted for exactly the one cycle after the edge where q[i] changed.
REQ-022 evt_cnt_o increments each clock by popcount(q_next ^ q) and saturates at 2^CW-1; it does not wrap.
REQ-023 cnt_clr_i and a same-cycle increment: the clear wins and evt_cnt_o becomes 0; that cycle's events are discarded.
REQ-024 Channels are fully independent; no cross-channel coupling except the shared counter.

Reset
REQ-025 On rst: q=QINIT replicated, qbar=~q, chg_o=0, evt_cnt_o=0.
REQ-026 On rst, every previous-value register loads the current input, so no spurious event occurs on the first cycle after reset.
REQ-027 rst overrides all events in the same cycle, including a reset asserted mid-operation, and no chg_o is generated for the reset-induced q change.

Configuration
REQ-028 Macro MIOC_FLOP_BANK_SYNC_EN: when defined, set_i, rpe_i and rne_i each pass through a 2-flop synchronizer before edge detection, latency becomes 3 clocks, and synchronizer flops load the current raw input on rst. When undefined, inputs feed edge detection directly with 1-clock latency.

Structure
REQ-029 A shared package mioc_pkg holds the RST_PRIO encoding constants (PRIO_RESET=1, PRIO_SET=0) and the default NCH/CW values.
REQ-030 One sub-module, mioc_flop_chan, implements a single channel (edge detection, priority, q, change flag) and is instantiated NCH times.
REQ-031 The counter and popcount reside in the top level.

Verification
REQ-032 rst then QINIT=0; set_i[0] 0->1 -> q=8'h01 one clock later, chg_o=8'h01 for one cycle, evt_cnt_o=1.
REQ-033 q[3]=1; rne_i[3] 1->0 -> q[3]=0 after one clock; a subsequent rne_i 0->1 leaves q unchanged.
REQ-034 set_i[5] and rpe_i[5] rise in the same cycle: with RST_PRIO=1, q[5]=0; with RST_PRIO=0, q[5]=1.
REQ-035 CW=4: 20 single-channel toggles -> evt_cnt_o stops at 15; cnt_clr_i coincident with a toggle -> evt_cnt_o=0.
REQ-036 set_i=8'hFF held high through rst -> no event after reset deasserts, q=QINIT, chg_o=0.
REQ-037 With MIOC_FLOP_BANK_SYNC_EN defined, set_i[1] rise -> q[1]=1 exactly three clocks later.
